pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters: N, default 32, PC/address width; RESET_VECTOR, default 0, PC after reset; TRAP_VECTOR, default 32'h0000_0100, misaligned-redirect target; MAX_WAIT, default 15, fetch-ack timeout in cycles (1..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-004 imem_ack  input  1  instruction memory: instruction at PC_Value is available this cycle.
REQ-005 jump  input  1  unconditional redirect request, sampled only in EXEC.
REQ-006 jump_target  input  N  jump destination.
REQ-007 branch_taken  input  1  conditional redirect request, sampled only in EXEC.
REQ-008 branch_target  input  N  branch destination.
REQ-009 stall  input  1  hold current instruction, sampled only in EXEC.
REQ-010 halt  input  1  stop sequencing, sampled only in EXEC.
REQ-011 PC_Value  output  N  registered current PC.
REQ-012 Next_PC  output  N  combinational PC to be loaded at the end of the current EXEC cycle.
REQ-013 imem_req  output  1  fetch request, high in FETCH.
REQ-014 instr_valid  output  1  high in EXEC: datapath may execute the instruction at PC_Value.
REQ-015 misaligned_trap  output  1  registered one-cycle pulse on misaligned redirect.
REQ-016 fetch_error  output  1  sticky, set on fetch timeout.
REQ-017 halted  output  1  high in HALTED.

Function
REQ-018 FSM states: IDLE, FETCH, EXEC, HALTED; all outputs are decoded from registered state.
REQ-019 IDLE: one cycle after reset release, then go to FETCH unconditionally.
REQ-020 FETCH: imem_req=1, wait counter increments each cycle; if imem_ack=1, go to EXEC and clear counter; if counter reaches MAX_WAIT without ack, set fetch_error and go to HALTED.
REQ-021 An imem_ack arriving in the same cycle the counter reaches MAX_WAIT counts as success, with no error.
REQ-022 EXEC: instr_valid=1; priority halt > stall > jump > branch_taken > sequential.
REQ-023 EXEC and halt=1: PC unchanged, go to HALTED.
REQ-024 EXEC and stall=1 (halt=0): PC unchanged, stay in EXEC, instr_valid stays 1.
REQ-025 EXEC otherwise: PC_Value <= Next_PC, go to FETCH.
REQ-026 Next_PC = jump_target if jump; else branch_target if branch_taken; else PC_Value+4, modulo 2^N (wraps from 0xFFFF_FFFC to 0); equals PC_Value in all non-EXEC states and on halt/stall.
REQ-027 A selected redirect target with bits [1:0] != 0 makes Next_PC = TRAP_VECTOR and pulses misaligned_trap in the following cycle; sequential PC+4 never traps.
REQ-028 HALTED: imem_req=0, instr_valid=0, PC held, halted=1; leave only by reset.
REQ-029 jump, branch_taken, stall and halt have no effect outside EXEC; imem_ack has no effect outside FETCH.

Reset
REQ-030 reset=0 asynchronously sets: state IDLE, PC_Value=RESET_VECTOR, counter=0, imem_req=0, instr_valid=0, misaligned_trap=0, fetch_error=0, halted=0.
REQ-031 reset asserted in any state, including mid-FETCH or mid-stall, aborts the operation with no partial PC update; after release, sequencing restarts at IDLE.

Verification
REQ-032 Sequential: reset release, imem_ack on the 2nd FETCH cycle each time -> PC 0,4,8,C; instr_valid one cycle per instruction; imem_req high exactly during FETCH.
REQ-033 Redirect priority: EXEC with jump=1 to 0x40 and branch_taken=1 to 0x80 -> PC=0x40; EXEC with branch_taken=1 only, target 0x80 -> PC=0x80.
REQ-034 Misaligned: jump_target=0x42 -> PC=0x100, misaligned_trap high exactly one cycle.
REQ-035 Timeout: MAX_WAIT=15, imem_ack held 0 -> fetch_error=1 and halted=1 after 15 FETCH cycles; ack on cycle 15 -> EXEC with no error.
REQ-036 Stall/halt: stall=1 for 3 EXEC cycles -> PC held, instr_valid=1 throughout; then halt=1 -> HALTED, later jump ignored.
REQ-037 Async reset: reset low mid-stall, between clock edges -> outputs take reset values before the next edge; PC=0xFFFF_FFFC sequential -> wraps to 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch / redirect bus between the PC sequencer and its datapath.
// master is the sequencer side; slave is the datapath / memory side.
interface pc_sequencer_if #(
    parameter int N = 32
);
    logic         imem_ack;
    logic         jump;
    logic [N-1:0] jump_target;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         stall;
    logic         halt;
    logic [N-1:0] PC_Value;
    logic [N-1:0] Next_PC;
    logic         imem_req;
    logic         instr_valid;
    logic         misaligned_trap;
    logic         fetch_error;
    logic         halted;

    modport master (
        input  imem_ack, jump, jump_target, branch_taken, branch_target, stall, halt,
        output PC_Value, Next_PC, imem_req, instr_valid, misaligned_trap, fetch_error, halted
    );

    modport slave (
        output imem_ack, jump, jump_target, branch_taken, branch_target, stall, halt,
        input  PC_Value, Next_PC, imem_req, instr_valid, misaligned_trap, fetch_error, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with redirects, stall,
// halt, misaligned-target trap and fetch-ack timeout.
module pc_sequencer #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = '0,
    parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0000_0100),
    parameter int           MAX_WAIT     = 15
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] pc, pc_nxt;
    logic [N-1:0] next_pc;
    logic [N-1:0] target;
    logic [7:0]   wait_cnt, wait_cnt_nxt;
    logic         err, err_nxt;
    logic         trap, trap_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= RESET_VECTOR;
            wait_cnt <= '0;
            err      <= 1'b0;
            trap     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
            trap     <= trap_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        trap_nxt     = 1'b0;
        next_pc      = pc;
        target       = '0;
        unique case (state)
            S_IDLE: begin
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end
            S_FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (bus.imem_ack) begin
                    state_nxt    = S_EXEC;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    state_nxt    = S_HALTED;
                    err_nxt      = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_EXEC: begin
                if (bus.halt) begin
                    state_nxt = S_HALTED;
                end else if (!bus.stall) begin
                    target = bus.jump ? bus.jump_target : bus.branch_target;
                    if ((bus.jump || bus.branch_taken) && (target[1:0] != 2'b00)) begin
                        next_pc  = TRAP_VECTOR;
                        trap_nxt = 1'b1;
                    end else if (bus.jump || bus.branch_taken) begin
                        next_pc = target;
                    end else begin
                        next_pc = pc + N'(4);
                    end
                    pc_nxt    = next_pc;
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.PC_Value        = pc;
    assign bus.Next_PC         = next_pc;
    assign bus.imem_req        = (state == S_FETCH);
    assign bus.instr_valid     = (state == S_EXEC);
    assign bus.halted          = (state == S_HALTED);
    assign bus.misaligned_trap = trap;
    assign bus.fetch_error     = err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] TRAP     = 32'h0000_0100;
    localparam int          M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   chk_en  = 1'b0;

    pc_sequencer_if #(.N(32)) bus ();

    pc_sequencer #(
        .N(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: spec-level phase, PC, count of FETCH cycles spent so far.
    int          m_st   = M_IDLE;
    logic [31:0] m_pc   = 32'h0;
    int          m_nf   = 0;
    bit          m_err  = 1'b0;
    bit          m_trap = 1'b0;

    function automatic bit redirect_bad();
        longint t;
        if (m_st != M_EXEC || bus.halt || bus.stall) return 1'b0;
        if (!bus.jump && !bus.branch_taken) return 1'b0;
        t = bus.jump ? longint'(bus.jump_target) : longint'(bus.branch_target);
        return (t % 4) != 0;
    endfunction

    function automatic logic [31:0] exp_next();
        longint t;
        if (m_st != M_EXEC || bus.halt || bus.stall) return m_pc;
        if (redirect_bad()) return TRAP;
        if (bus.jump) return bus.jump_target;
        if (bus.branch_taken) return bus.branch_target;
        t = (longint'(m_pc) + 4) % 64'h1_0000_0000;
        return 32'(t);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st <= M_IDLE; m_pc <= 32'h0; m_nf <= 0; m_err <= 1'b0; m_trap <= 1'b0;
        end else begin
            m_trap <= redirect_bad();
            case (m_st)
                M_IDLE: begin m_st <= M_FETCH; m_nf <= 0; end
                M_FETCH: begin
                    m_nf <= m_nf + 1;
                    if (bus.imem_ack) m_st <= M_EXEC;
                    else if (m_nf + 1 == MAX_WAIT) begin m_st <= M_HALT; m_err <= 1'b1; end
                end
                M_EXEC: begin
                    if (bus.halt) m_st <= M_HALT;
                    else if (!bus.stall) begin m_pc <= exp_next(); m_st <= M_FETCH; m_nf <= 0; end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("PC_Value", bus.PC_Value, m_pc);
            chk("Next_PC", bus.Next_PC, exp_next());
            chk("imem_req", 32'(bus.imem_req), 32'(m_st == M_FETCH));
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_st == M_EXEC));
            chk("halted", 32'(bus.halted), 32'(m_st == M_HALT));
            chk("fetch_error", 32'(bus.fetch_error), 32'(m_err));
            chk("misaligned_trap", 32'(bus.misaligned_trap), 32'(m_trap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.imem_ack = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
        bus.stall = 1'b0; bus.halt = 1'b0;
    endtask

    // Restart: leaves the bench just after the first FETCH edge.
    task automatic restart();
        clr();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // From FETCH cycle 1: ack on cycle `delay`, then one EXEC with given redirects.
    task automatic instr(input int delay, input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bt);
        repeat (delay - 1) begin bus.imem_ack = 1'b0; tick(); end
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.jump = j; bus.jump_target = jt; bus.branch_taken = b; bus.branch_target = bt;
        tick();
        clr();
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        clr();
        bus.jump_target = 32'h0; bus.branch_target = 32'h0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst PC", bus.PC_Value, 32'h0);
        chk("rst imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst halted", 32'(bus.halted), 32'h0);
        chk("rst fetch_error", 32'(bus.fetch_error), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("fetch imem_req", 32'(bus.imem_req), 32'h1);

        // Sequential 0,4,8 then C
        instr(2, 1'b0, 32'h0, 1'b0, 32'h0);
        instr(2, 1'b0, 32'h0, 1'b0, 32'h0);
        instr(2, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq PC", bus.PC_Value, 32'hC);

        // Jump beats branch
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.jump = 1'b1; bus.jump_target = 32'h40;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
        #1;
        chk("prio Next_PC", bus.Next_PC, 32'h40);
        tick();
        clr();
        chk("prio PC", bus.PC_Value, 32'h40);
        instr(1, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("branch PC", bus.PC_Value, 32'h80);

        // Misaligned jump
        instr(3, 1'b1, 32'h42, 1'b0, 32'h0);
        chk("trap PC", bus.PC_Value, 32'h100);
        chk("trap pulse", 32'(bus.misaligned_trap), 32'h1);
        tick();
        chk("trap clear", 32'(bus.misaligned_trap), 32'h0);

        // Stall for three EXEC cycles, then halt; later jump ignored
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.stall = 1'b1;
        repeat (3) begin
            chk("stall valid", 32'(bus.instr_valid), 32'h1);
            chk("stall PC", bus.PC_Value, 32'h100);
            tick();
        end
        bus.stall = 1'b0; bus.halt = 1'b1;
        #1;
        chk("halt Next_PC", bus.Next_PC, 32'h100);
        tick();
        clr();
        chk("halt state", 32'(bus.halted), 32'h1);
        bus.jump = 1'b1; bus.jump_target = 32'h200;
        tick();
        tick();
        chk("halted PC", bus.PC_Value, 32'h100);
        chk("halted imem_req", 32'(bus.imem_req), 32'h0);

        // Timeout: no ack for MAX_WAIT fetch cycles
        restart();
        repeat (MAX_WAIT - 1) tick();
        chk("pre-timeout err", 32'(bus.fetch_error), 32'h0);
        tick();
        chk("timeout err", 32'(bus.fetch_error), 32'h1);
        chk("timeout halted", 32'(bus.halted), 32'h1);

        // Ack on the last allowed cycle succeeds
        restart();
        repeat (MAX_WAIT - 1) tick();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        chk("late ack valid", 32'(bus.instr_valid), 32'h1);
        chk("late ack err", 32'(bus.fetch_error), 32'h0);

        // Async reset mid-stall, between edges
        bus.jump = 1'b1; bus.jump_target = 32'h300;
        tick();
        clr();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        bus.stall = 1'b1;
        tick();
        tick();
        chk("pre-reset PC", bus.PC_Value, 32'h300);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async PC", bus.PC_Value, 32'h0);
        chk("async valid", 32'(bus.instr_valid), 32'h0);
        chk("async imem_req", 32'(bus.imem_req), 32'h0);
        restart();

        // Wrap from 0xFFFF_FFFC
        instr(1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("top PC", bus.PC_Value, 32'hFFFF_FFFC);
        instr(2, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap PC", bus.PC_Value, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int ack_pct;
            ack_pct = ((c % 1000) < 150) ? 3 : 45;
            bus.imem_ack      = ($urandom_range(99) < ack_pct);
            bus.jump          = ($urandom_range(99) < 20);
            bus.branch_taken  = ($urandom_range(99) < 25);
            bus.stall         = ($urandom_range(99) < 20);
            bus.halt          = ($urandom_range(99) < 3);
            bus.jump_target   = rand_target();
            bus.branch_target = rand_target();
            if ((bus.halted && $urandom_range(9) == 0) || $urandom_range(199) == 0)
                reset_n = 1'b0;
            else
                reset_n = 1'b1;
            tick();
        end

        clr();
        reset_n = 1'b1;
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
